// File: rtl/dcache_pkg.sv
// dcache shared types: FSM states, default geometry
// and helper functions for address field widths.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITE_BACK,
      MEM_READ,
      UPDATE
   } state_t;

   localparam int DEF_LINES  = 8;
   localparam int DEF_WORDS  = 4;
   localparam int DEF_ADDR_W = 8;
   localparam int BYTE_W     = 8;

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int off_w(input int words);
      return $clog2(words);
   endfunction

   function automatic int tag_w(input int aw, input int lines,
                                input int words);
      return aw - $clog2(lines) - $clog2(words);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache line storage: valid/dirty with async clear,
// tag and data arrays, byte write and block fill.
module dcache_array #(
   parameter int LINES = 8,
   parameter int IW    = 3,
   parameter int OW    = 2,
   parameter int TW    = 3,
   parameter int BW    = 32
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [IW-1:0] idx,
   input  logic          wr_en,
   input  logic [OW-1:0] wr_off,
   input  logic [7:0]    wr_byte,
   input  logic          fill_en,
   input  logic [BW-1:0] fill_data,
   input  logic          upd_en,
   input  logic [TW-1:0] upd_tag,
   output logic          valid,
   output logic          dirty,
   output logic [TW-1:0] tag,
   output logic [BW-1:0] data
);

   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TW-1:0]    tag_q  [LINES];
   logic [BW-1:0]    data_q [LINES];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (upd_en) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (wr_en) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // Tag and data are left uncleared; valid gates their use.
   always_ff @(posedge CLK) begin
      if (fill_en)
         data_q[idx] <= fill_data;
      else if (wr_en)
         data_q[idx][{wr_off, 3'b000} +: 8] <= wr_byte;
      if (upd_en)
         tag_q[idx] <= upd_tag;
   end

   assign valid = valid_q[idx];
   assign dirty = dirty_q[idx];
   assign tag   = tag_q[idx];
   assign data  = data_q[idx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back write-allocate data cache:
// hit logic, miss FSM and CPU/memory side muxing.
module dcache
   import dcache_pkg::*;
#(
   parameter int NUM_LINES       = DEF_LINES,
   parameter int WORDS_PER_BLOCK = DEF_WORDS,
   parameter int ADDR_W          = DEF_ADDR_W,
   localparam int IW = idx_w(NUM_LINES),
   localparam int OW = off_w(WORDS_PER_BLOCK),
   localparam int TW = tag_w(ADDR_W, NUM_LINES, WORDS_PER_BLOCK),
   localparam int BW = BYTE_W * WORDS_PER_BLOCK
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             READ,
   input  logic             WRITE,
   input  logic [ADDR_W-1:0] ADDRESS,
   input  logic [7:0]       WRITEDATA,
   output logic [7:0]       READDATA,
   output logic             BUSYWAIT,
   output logic             mem_read,
   output logic             mem_write,
   output logic [TW+IW-1:0] mem_address,
   output logic [BW-1:0]    mem_writedata,
   input  logic [BW-1:0]    mem_readdata,
   input  logic             mem_busywait
);

   state_t state, state_n;
   logic   wr_ack;

   logic [TW-1:0] tag_a;
   logic [IW-1:0] idx_a;
   logic [OW-1:0] off_a;

   assign tag_a = ADDRESS[ADDR_W-1 -: TW];
   assign idx_a = ADDRESS[OW +: IW];
   assign off_a = ADDRESS[OW-1:0];

   logic          l_valid, l_dirty;
   logic [TW-1:0] l_tag;
   logic [BW-1:0] l_data;
   logic          hit;
   logic          wr_en, fill_en, upd_en, busy;

   dcache_array #(
      .LINES(NUM_LINES),
      .IW   (IW),
      .OW   (OW),
      .TW   (TW),
      .BW   (BW)
   ) u_array (
      .CLK      (CLK),
      .RESET    (RESET),
      .idx      (idx_a),
      .wr_en    (wr_en),
      .wr_off   (off_a),
      .wr_byte  (WRITEDATA),
      .fill_en  (fill_en),
      .fill_data(mem_readdata),
      .upd_en   (upd_en),
      .upd_tag  (tag_a),
      .valid    (l_valid),
      .dirty    (l_dirty),
      .tag      (l_tag),
      .data     (l_data)
   );

   assign hit = l_valid & (l_tag == tag_a);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         wr_ack <= 1'b0;
      else if (!WRITE)
         wr_ack <= 1'b0;
      else if (wr_en)
         wr_ack <= 1'b1;
   end

   always_comb begin
      state_n       = state;
      busy          = 1'b0;
      wr_en         = 1'b0;
      fill_en       = 1'b0;
      upd_en        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      unique case (state)
         IDLE: begin
            if ((READ | WRITE) & !hit) begin
               busy    = 1'b1;
               state_n = l_dirty ? WRITE_BACK : MEM_READ;
            end else if (WRITE) begin
               busy  = !wr_ack;
               wr_en = !wr_ack;
            end
         end
         WRITE_BACK: begin
            busy          = 1'b1;
            mem_write     = 1'b1;
            mem_address   = {l_tag, idx_a};
            mem_writedata = l_data;
            if (!mem_busywait)
               state_n = MEM_READ;
         end
         MEM_READ: begin
            busy        = 1'b1;
            mem_read    = 1'b1;
            mem_address = {tag_a, idx_a};
            if (!mem_busywait) begin
               fill_en = 1'b1;
               state_n = UPDATE;
            end
         end
         UPDATE: begin
            busy    = 1'b1;
            upd_en  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Held low while in reset even if the CPU keeps a request up.
   assign BUSYWAIT = busy & RESET;

   assign READDATA = (state == IDLE && READ && !WRITE && hit)
                   ? l_data[{off_a, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache with a latency memory
// model and a scoreboard of expected memory transfers.
module tb_dcache;

   localparam int LAT = 2;

   logic        CLK, RESET, READ, WRITE;
   logic [7:0]  ADDRESS, WRITEDATA, READDATA;
   logic        BUSYWAIT;
   logic        mem_read, mem_write, mem_busywait;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata, mem_readdata;

   dcache dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .READ         (READ),
      .WRITE        (WRITE),
      .ADDRESS      (ADDRESS),
      .WRITEDATA    (WRITEDATA),
      .READDATA     (READDATA),
      .BUSYWAIT     (BUSYWAIT),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_writedata(mem_writedata),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic        wr;
      logic [5:0]  a;
      logic [31:0] d;
   } txn_t;

   txn_t        exp_q[$];
   logic [31:0] mem [64];
   int          cnt = 0;
   int          ntx = 0;
   logic        req;

   assign req          = mem_read | mem_write;
   assign mem_busywait = req && (cnt < LAT);
   assign mem_readdata = mem[mem_address];

   // Memory: each transfer completes when busywait is sampled low.
   always @(posedge CLK) begin
      if (req && !mem_busywait) begin
         txn_t e;
         ntx++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL mem_unexpected observed=%h expected=none",
                   {mem_write, mem_address});
         end else begin
            e = exp_q.pop_front();
            chk("mem_kind", {31'd0, mem_write}, {31'd0, e.wr});
            chk("mem_addr", {26'd0, mem_address}, {26'd0, e.a});
            if (e.wr)
               chk("mem_wdata", mem_writedata, e.d);
         end
         if (mem_write)
            mem[mem_address] = mem_writedata;
         cnt <= 0;
      end else if (req) begin
         cnt <= cnt + 1;
      end else begin
         cnt <= 0;
      end
   end

   task automatic push_rd(input logic [5:0] a);
      exp_q.push_back('{wr: 1'b0, a: a, d: 32'h0});
   endtask

   task automatic push_wb(input logic [5:0] a, input logic [31:0] d);
      exp_q.push_back('{wr: 1'b1, a: a, d: d});
   endtask

   // One CPU access: returns stall cycles and the byte seen on release.
   task automatic access(input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d,
                         output int stall, output logic [7:0] rd);
      @(negedge CLK);
      READ = r;
      WRITE = w;
      ADDRESS = a;
      WRITEDATA = d;
      stall = 0;
      #1;
      while (BUSYWAIT && stall < 100) begin
         @(negedge CLK);
         #1;
         stall++;
      end
      rd = READDATA;
      READ = 1'b0;
      WRITE = 1'b0;
   endtask

   task automatic step(input string tag, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d,
                       input int exp_stall, input logic [7:0] exp_rd);
      int         st;
      logic [7:0] rd;
      access(r, w, a, d, st, rd);
      chk({tag, "_stall"}, st, exp_stall);
      if (r && !w)
         chk({tag, "_data"}, {24'd0, rd}, {24'd0, exp_rd});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      for (int i = 0; i < 64; i++)
         mem[i] = 32'h01010101 * i;
      mem[1]  = 32'h44332211;
      mem[4]  = 32'h0F0E0D0C;
      mem[9]  = 32'hDDCCBBAA;
      mem[63] = 32'h87654321;

      RESET = 1'b0;
      READ = 1'b0;
      WRITE = 1'b0;
      ADDRESS = 8'h00;
      WRITEDATA = 8'h00;
      #13;
      chk("rst_busy", {31'd0, BUSYWAIT}, 32'd0);
      chk("rst_mrd", {31'd0, mem_read}, 32'd0);
      chk("rst_mwr", {31'd0, mem_write}, 32'd0);
      chk("rst_maddr", {26'd0, mem_address}, 32'd0);
      chk("rst_mwdata", mem_writedata, 32'd0);
      chk("rst_rdata", {24'd0, READDATA}, 32'd0);
      @(negedge CLK);
      RESET = 1'b1;

      push_rd(6'h01);
      step("cold_rd04", 1, 0, 8'h04, 8'h00, LAT + 3, 8'h11);
      n0 = ntx;
      step("hit_rd06", 1, 0, 8'h06, 8'h00, 0, 8'h33);
      chk("hit_no_mem", ntx, n0);
      step("wr_hit05", 0, 1, 8'h05, 8'hAA, 1, 8'h00);
      step("rd05", 1, 0, 8'h05, 8'h00, 0, 8'hAA);

      push_wb(6'h01, 32'h4433AA11);
      push_rd(6'h09);
      step("dirty_rd24", 1, 0, 8'h24, 8'h00, 2 * LAT + 4, 8'hAA);
      chk("wb_mem1", mem[1], 32'h4433AA11);

      @(negedge CLK);
      READ = 1'b1;
      ADDRESS = 8'h04;
      @(posedge CLK);
      #1;
      chk("mr_active", {31'd0, mem_read}, 32'd1);
      chk("mr_addr", {26'd0, mem_address}, 32'h01);
      RESET = 1'b0;
      #1;
      chk("abort_mrd", {31'd0, mem_read}, 32'd0);
      chk("abort_busy", {31'd0, BUSYWAIT}, 32'd0);
      chk("abort_maddr", {26'd0, mem_address}, 32'd0);
      READ = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;

      push_rd(6'h01);
      step("remiss_rd04", 1, 0, 8'h04, 8'h00, LAT + 3, 8'h11);
      step("rw_both06", 1, 1, 8'h06, 8'h5A, 1, 8'h00);
      step("rd06", 1, 0, 8'h06, 8'h00, 0, 8'h5A);

      push_wb(6'h01, 32'h445AAA11);
      push_rd(6'h09);
      step("dirty_rd26", 1, 0, 8'h26, 8'h00, 2 * LAT + 4, 8'hCC);

      push_rd(6'h3F);
      step("wrap_rdFF", 1, 0, 8'hFF, 8'h00, LAT + 3, 8'h87);
      step("wr_hitFE", 0, 1, 8'hFE, 8'h55, 1, 8'h00);
      step("rdFE", 1, 0, 8'hFE, 8'h00, 0, 8'h55);

      push_rd(6'h04);
      step("wr_miss10", 0, 1, 8'h10, 8'h77, LAT + 4, 8'h00);
      step("rd10", 1, 0, 8'h10, 8'h00, 0, 8'h77);
      step("rd13", 1, 0, 8'h13, 8'h00, 0, 8'h0F);

      repeat (3) @(negedge CLK);
      chk("queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
